pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates the stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers, covering three cases: load-use hazards, taken-branch/jump redirects (with configurable fetch-latency bubbles), and multi-cycle EX operations (mul/div) via a start/done handshake. It sits beside the ID/EX register and drives its flush input plus a new hold input.

Parameters:
LOAD_SEL, 2'b01, wd_sel encoding that marks a load (write-back from DRAM)
REDIRECT_CYCLES, 1, extra cycles IF/ID stays flushed after a redirect (0..7); 0 means no REDIRECT state
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_id_i  in  5  ID-stage source register 1
rs2_id_i  in  5  ID-stage source register 2
rs1_used_id_i  in  1  ID instruction reads rs1
rs2_used_id_i  in  1  ID instruction reads rs2
instr_valid_id_i  in  1  ID instruction valid
instr_valid_ex_i  in  1  EX instruction valid
wr_ex_i  in  5  EX destination register
rf_we_ex_i  in  1  EX register-file write enable
wd_sel_ex_i  in  2  EX write-back source select
branch_taken_ex_i  in  1  EX resolved a taken branch or jump
mc_req_ex_i  in  1  EX instruction is multi-cycle
mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
mc_start_o  out  1  start pulse to multi-cycle unit
stall_pc_o  out  1  hold PC
stall_ifid_o  out  1  hold IF/ID
flush_ifid_o  out  1  clear IF/ID
hold_idex_o  out  1  hold ID/EX contents
flush_idex_o  out  1  insert bubble into ID/EX
flush_exmem_o  out  1  insert bubble into EX/MEM
state_o  out  2  current state (debug)
stall_cnt_o  out  CNT_W  total stall cycles, saturating

Behaviour:
- States: RUN=2'd0, MC_WAIT=2'd2, REDIRECT=2'd3 (2'd1 unused; treat as RUN). Reset: state=RUN, redirect counter=0, stall_cnt_o=0. All control outputs are combinational from state and inputs, and therefore read 0 while in reset.
- Load-use hazard (LU) = instr_valid_ex_i & rf_we_ex_i & (wd_sel_ex_i==LOAD_SEL) & (wr_ex_i!=0) & instr_valid_id_i & ((rs1_used_id_i & rs1_id_i==wr_ex_i) | (rs2_used_id_i & rs2_id_i==wr_ex_i)).
- Branch taken (BR) = branch_taken_ex_i & instr_valid_ex_i.
- RUN, priority BR > multi-cycle > LU:
  - BR: flush_ifid_o=1 and flush_idex_o=1, no stalls, mc_start_o=0. Next state is REDIRECT with counter=REDIRECT_CYCLES if the parameter is >0, else RUN.
  - else mc_req_ex_i & instr_valid_ex_i: mc_start_o=1 for exactly this cycle; stall_pc_o, stall_ifid_o, hold_idex_o and flush_exmem_o all =1. Next state MC_WAIT.
  - else LU: stall_pc_o=1, stall_ifid_o=1, flush_idex_o=1 for exactly one cycle; stays in RUN. The load then reaches MEM and forwarding covers the dependency.
  - else all outputs 0.
- MC_WAIT:
  - stall_pc_o, stall_ifid_o, hold_idex_o and flush_exmem_o stay 1 every cycle until mc_done_i=1.
  - In the mc_done_i cycle all four deassert, EX/MEM captures the result at that edge, and the next state is RUN.
  - BR, LU and mc_req_ex_i are ignored in MC_WAIT. mc_done_i outside MC_WAIT is ignored.
  - No timeout: the block waits indefinitely.
- REDIRECT:
  - flush_ifid_o=1, all stalls 0, BR/LU/mc_req ignored (EX and ID hold bubbles).
  - Counter decrements each cycle; the state returns to RUN in the cycle after the counter reads 1, giving exactly REDIRECT_CYCLES cycles in REDIRECT.
- Simultaneous events:
  - BR wins over LU and mc_req in the same cycle.
  - flush_idex_o and hold_idex_o are never both 1.
  - flush wins over stall on IF/ID: stall_ifid_o is never 1 while flush_ifid_o=1.
- stall_cnt_o increments by 1 on each cycle with stall_pc_o=1 and saturates at all-ones.
- Reset asserted mid-operation (any state) returns immediately to RUN with all outputs 0. A pending multi-cycle operation is abandoned; its late mc_done_i is ignored.

Test Plan:
- Load-use: EX is a load writing x5 (rf_we=1, wd_sel=LOAD_SEL); ID reads rs2=x5 with rs2_used=1 -> one cycle of stall_pc/stall_ifid/flush_idex=1, then 0; stall_cnt_o=1. Repeat with wr_ex_i=0 or rs2_used=0 -> no stall.
- Taken branch, REDIRECT_CYCLES=2: BR in cycle N -> flush_ifid and flush_idex=1 in N; flush_ifid=1 only in N+1 and N+2 with state_o=3; RUN again at N+3.
- Multi-cycle op: mc_req_ex in cycle N, mc_done_i pulsed at N+5 -> mc_start_o=1 only at N; stalls, hold_idex and flush_exmem=1 for N..N+4, all 0 at N+5; stall_cnt_o=5.
- Priority: BR, mc_req and LU all asserted together -> flushes only, mc_start_o=0, no stall. LU raised during MC_WAIT -> no flush_idex_o.
- Reset mid-MC_WAIT: assert rst_n=0 at cycle 3 of the wait -> outputs 0 and state_o=0 immediately; a later mc_done_i has no effect; stall_cnt_o=0.
- Saturation: CNT_W=4, 20 LU stall cycles -> stall_cnt_o holds 4'hF.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipe_hazard_if #(parameter int CNT_W = 16);
    logic [4:0]       rs1_id_i;
    logic [4:0]       rs2_id_i;
    logic             rs1_used_id_i;
    logic             rs2_used_id_i;
    logic             instr_valid_id_i;
    logic             instr_valid_ex_i;
    logic [4:0]       wr_ex_i;
    logic             rf_we_ex_i;
    logic [1:0]       wd_sel_ex_i;
    logic             branch_taken_ex_i;
    logic             mc_req_ex_i;
    logic             mc_done_i;
    logic             mc_start_o;
    logic             stall_pc_o;
    logic             stall_ifid_o;
    logic             flush_ifid_o;
    logic             hold_idex_o;
    logic             flush_idex_o;
    logic             flush_exmem_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i, instr_valid_id_i,
               instr_valid_ex_i, wr_ex_i, rf_we_ex_i, wd_sel_ex_i, branch_taken_ex_i,
               mc_req_ex_i, mc_done_i,
        input  mc_start_o, stall_pc_o, stall_ifid_o, flush_ifid_o, hold_idex_o,
               flush_idex_o, flush_exmem_o, state_o, stall_cnt_o
    );

    modport slave (
        input  rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i, instr_valid_id_i,
               instr_valid_ex_i, wr_ex_i, rf_we_ex_i, wd_sel_ex_i, branch_taken_ex_i,
               mc_req_ex_i, mc_done_i,
        output mc_start_o, stall_pc_o, stall_ifid_o, flush_ifid_o, hold_idex_o,
               flush_idex_o, flush_exmem_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, redirect and multi-cycle stall/flush sequencer for the 5-stage core
module pipe_hazard_ctrl #(
    parameter logic [1:0] LOAD_SEL        = 2'b01,
    parameter int         REDIRECT_CYCLES = 1,
    parameter int         CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_hazard_if.slave   bus
);
    typedef enum logic [1:0] {RUN = 2'd0, SPARE = 2'd1, MC_WAIT = 2'd2, REDIRECT = 2'd3} state_t;
    localparam logic [2:0] RC = 3'(REDIRECT_CYCLES);

    state_t           state;
    logic [2:0]       rcnt;
    logic [CNT_W-1:0] cnt;
    logic             lu, br, run, br_run, mc_run, lu_run, mc_wait, redir;

    assign lu = bus.instr_valid_ex_i & bus.rf_we_ex_i & (bus.wd_sel_ex_i == LOAD_SEL) &
                (bus.wr_ex_i != 5'd0) & bus.instr_valid_id_i &
                ((bus.rs1_used_id_i & (bus.rs1_id_i == bus.wr_ex_i)) |
                 (bus.rs2_used_id_i & (bus.rs2_id_i == bus.wr_ex_i)));
    assign br = bus.branch_taken_ex_i & bus.instr_valid_ex_i;
    // the spare encoding behaves as RUN; outputs are forced low while reset is held
    assign run     = rst_n & ~state[1];
    assign br_run  = run & br;
    assign mc_run  = run & ~br & bus.mc_req_ex_i & bus.instr_valid_ex_i;
    assign lu_run  = run & ~br & ~(bus.mc_req_ex_i & bus.instr_valid_ex_i) & lu;
    assign mc_wait = rst_n & (state == MC_WAIT) & ~bus.mc_done_i;
    assign redir   = rst_n & (state == REDIRECT);

    assign bus.mc_start_o    = mc_run;
    assign bus.stall_pc_o    = mc_run | mc_wait | lu_run;
    assign bus.stall_ifid_o  = mc_run | mc_wait | lu_run;
    assign bus.flush_ifid_o  = br_run | redir;
    assign bus.hold_idex_o   = mc_run | mc_wait;
    assign bus.flush_idex_o  = br_run | lu_run;
    assign bus.flush_exmem_o = mc_run | mc_wait;
    assign bus.state_o       = state;
    assign bus.stall_cnt_o   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rcnt  <= 3'd0;
            cnt   <= '0;
        end else begin
            cnt <= (bus.stall_pc_o && !(&cnt)) ? cnt + 1'b1 : cnt;
            if (br_run) begin
                state <= (REDIRECT_CYCLES > 0) ? REDIRECT : RUN;
                rcnt  <= RC;
            end else if (mc_run) begin
                state <= MC_WAIT;
            end else if (state == MC_WAIT && bus.mc_done_i) begin
                state <= RUN;
            end else if (state == REDIRECT) begin
                rcnt  <= rcnt - 3'd1;
                state <= (rcnt <= 3'd1) ? RUN : REDIRECT;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard stalls, redirects, multi-cycle waits and saturation
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    // control vector: {mc_start, stall_pc, stall_ifid, flush_ifid, hold_idex, flush_idex, flush_exmem}
    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] LUS   = 7'b0110010;
    localparam logic [6:0] BRF   = 7'b0001010;
    localparam logic [6:0] MCS   = 7'b1110101;
    localparam logic [6:0] MCW   = 7'b0110101;
    localparam logic [6:0] REDIR = 7'b0001000;

    pipe_hazard_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(.LOAD_SEL(2'b01), .REDIRECT_CYCLES(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.mc_start_o, bus.stall_pc_o, bus.stall_ifid_o, bus.flush_ifid_o,
                bus.hold_idex_o, bus.flush_idex_o, bus.flush_exmem_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] ec, input logic [1:0] es);
        chk({tag, ".ctl"}, 32'(ctl()), 32'(ec));
        chk({tag, ".state"}, 32'(bus.state_o), 32'(es));
    endtask

    task automatic clr();
        bus.rs1_id_i = 5'd0; bus.rs2_id_i = 5'd0;
        bus.rs1_used_id_i = 1'b0; bus.rs2_used_id_i = 1'b0;
        bus.instr_valid_id_i = 1'b0; bus.instr_valid_ex_i = 1'b0;
        bus.wr_ex_i = 5'd0; bus.rf_we_ex_i = 1'b0; bus.wd_sel_ex_i = 2'b00;
        bus.branch_taken_ex_i = 1'b0; bus.mc_req_ex_i = 1'b0; bus.mc_done_i = 1'b0;
    endtask

    // EX load to x5, ID reads it on rs2
    task automatic lu_rs2();
        bus.instr_valid_ex_i = 1'b1; bus.rf_we_ex_i = 1'b1; bus.wd_sel_ex_i = 2'b01;
        bus.wr_ex_i = 5'd5; bus.instr_valid_id_i = 1'b1;
        bus.rs2_id_i = 5'd5; bus.rs2_used_id_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        bus.branch_taken_ex_i = 1'b1; bus.instr_valid_ex_i = 1'b1;
        @(negedge clk);
        chk_ctl("reset", IDLE, 2'd0);
        chk("reset.cnt", 32'(bus.stall_cnt_o), 0);
        step(); clr(); rst_n = 1'b1;

        step(); lu_rs2();
        @(negedge clk); chk_ctl("lu_rs2", LUS, 2'd0);
        step(); clr();
        @(negedge clk); chk_ctl("lu_after", IDLE, 2'd0);
        chk("lu.cnt", 32'(bus.stall_cnt_o), 1);
        step(); lu_rs2(); bus.wr_ex_i = 5'd0; bus.rs2_id_i = 5'd0;
        @(negedge clk); chk_ctl("lu_x0", IDLE, 2'd0);
        step(); lu_rs2(); bus.rs2_used_id_i = 1'b0;
        @(negedge clk); chk_ctl("lu_unused", IDLE, 2'd0);
        step(); lu_rs2(); bus.wd_sel_ex_i = 2'b00;
        @(negedge clk); chk_ctl("lu_notload", IDLE, 2'd0);
        step(); lu_rs2(); bus.rs2_used_id_i = 1'b0; bus.rs1_id_i = 5'd5; bus.rs1_used_id_i = 1'b1;
        @(negedge clk); chk_ctl("lu_rs1", LUS, 2'd0);

        step(); clr(); bus.branch_taken_ex_i = 1'b1; bus.instr_valid_ex_i = 1'b1;
        @(negedge clk); chk_ctl("br_n", BRF, 2'd0);
        step(); clr(); lu_rs2(); bus.branch_taken_ex_i = 1'b1; bus.mc_req_ex_i = 1'b1;
        @(negedge clk); chk_ctl("br_n1", REDIR, 2'd3);
        step(); clr();
        @(negedge clk); chk_ctl("br_n2", REDIR, 2'd3);
        step();
        @(negedge clk); chk_ctl("br_n3", IDLE, 2'd0);
        chk("br.cnt", 32'(bus.stall_cnt_o), 2);

        step(); lu_rs2(); bus.branch_taken_ex_i = 1'b1; bus.mc_req_ex_i = 1'b1;
        @(negedge clk); chk_ctl("prio", BRF, 2'd0);
        step(); clr();
        @(negedge clk); chk_ctl("prio_n1", REDIR, 2'd3);
        step();
        @(negedge clk); chk_ctl("prio_n2", REDIR, 2'd3);
        step();
        @(negedge clk); chk_ctl("prio_n3", IDLE, 2'd0);

        step(); bus.mc_req_ex_i = 1'b1; bus.instr_valid_ex_i = 1'b1;
        @(negedge clk); chk_ctl("mc_n", MCS, 2'd0);
        step(); clr();
        @(negedge clk); chk_ctl("mc_n1", MCW, 2'd2);
        step(); lu_rs2();
        @(negedge clk); chk_ctl("mc_lu", MCW, 2'd2);
        step(); clr(); bus.branch_taken_ex_i = 1'b1; bus.instr_valid_ex_i = 1'b1; bus.mc_req_ex_i = 1'b1;
        @(negedge clk); chk_ctl("mc_br", MCW, 2'd2);
        step(); clr();
        @(negedge clk); chk_ctl("mc_n4", MCW, 2'd2);
        step(); bus.mc_done_i = 1'b1;
        @(negedge clk); chk_ctl("mc_done", IDLE, 2'd2);
        step(); clr();
        @(negedge clk); chk_ctl("mc_after", IDLE, 2'd0);
        chk("mc.cnt", 32'(bus.stall_cnt_o), 7);
        step(); bus.mc_done_i = 1'b1;
        @(negedge clk); chk_ctl("done_run", IDLE, 2'd0);

        step(); clr(); bus.mc_req_ex_i = 1'b1; bus.instr_valid_ex_i = 1'b1;
        step(); clr();
        step();
        step(); rst_n = 1'b0;
        @(negedge clk); chk_ctl("rst_mid", IDLE, 2'd0);
        chk("rst_mid.cnt", 32'(bus.stall_cnt_o), 0);
        step(); rst_n = 1'b1;
        step(); bus.mc_done_i = 1'b1;
        @(negedge clk); chk_ctl("late_done", IDLE, 2'd0);
        step(); clr();
        @(negedge clk); chk_ctl("late_after", IDLE, 2'd0);
        chk("late.cnt", 32'(bus.stall_cnt_o), 0);

        step(); lu_rs2();
        for (int i = 0; i < 20; i++) step();
        @(negedge clk); chk_ctl("sat", LUS, 2'd0);
        chk("sat.cnt", 32'(bus.stall_cnt_o), 15);
        step(); clr();
        @(negedge clk); chk("sat.hold", 32'(bus.stall_cnt_o), 15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
